uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  UART receiver: recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from serial line rx.
//  Sits downstream of the UART transmitter: the line-side consumer in loopback and link paths.
//  Runs entirely on clk; uses a 16x oversampling tick enable, not a derived clock.
//  Delivers each byte with a 1-cycle done strobe and flags framing errors.
// PARAMETERS
//  clock_freq   10000000  system clock frequency, Hz
//  baud_rate    9600      line bit rate, bits/s
//  OVERSAMPLE   16        ticks per bit; must be even and >= 8
// PORTS
//  clk      in   1  system clock, all logic on posedge
//  rst      in   1  synchronous, active-low reset (rst==0 resets on next posedge clk)
//  rx       in   1  asynchronous serial input, idle high
//  rx_data  out  8  last correctly framed byte; holds until next good frame
//  rx_done  out  1  1-clk pulse, rx_data updated in the same cycle
//  rx_err   out  1  1-clk pulse on framing error (stop bit sampled 0)
//  rx_busy  out  1  high whenever FSM is not IDLE
// BEHAVIOUR
//  - Reset: rx_data=8'h00, rx_done=0, rx_err=0, rx_busy=0, FSM=IDLE, counters=0, sync FFs=1.
//  - Input sync: 2-FF synchronizer on rx -> rx_s; FSM only ever reads rx_s.
//  - Tick: TICK_DIV = clock_freq/(baud_rate*OVERSAMPLE), integer truncation (defaults: 65).
//    Free-running counter 0..TICK_DIV-1; tick=1 for one clk when counter==TICK_DIV-1, then wraps to 0.
//  - FSM advances only on tick cycles; sample counter scnt (4 bits), bit index bidx (3 bits).
//    IDLE : rx_s==0 -> START, scnt=0. Otherwise stay.
//    START: scnt++; when scnt==OVERSAMPLE/2-1: rx_s==0 -> DATA, scnt=0, bidx=0;
//           rx_s==1 -> IDLE (glitch reject, no strobe).
//    DATA : scnt++; when scnt==OVERSAMPLE-1: shift rx_s into shreg MSB (LSB-first arrival), scnt=0;
//           bidx==7 -> STOP, else bidx++.
//    STOP : scnt++; when scnt==OVERSAMPLE-1: rx_s==1 -> rx_data<=shreg, rx_done=1;
//           rx_s==0 -> rx_err=1, rx_data unchanged; either way -> IDLE.
//  - Samples land at bit centre (±1 tick) since START aligns to mid-start-bit.
//  - rx_done/rx_err never both high; each strictly 1 clk wide, asserted in the FSM-exit tick cycle.
//  - Latency: rx_done ~9.5 bit times + 2 clk (sync) + ≤1 tick after falling start edge.
//  - Back-to-back frames: STOP exits at mid-stop-bit, so a start edge arriving right after is caught.
//  - rx held low (break): framing error pulse, then IDLE re-enters START each frame; no rx_done.
//  - Reset mid-frame: frame discarded, outputs to reset values, no strobe; next frame received normally.
//  - rx_busy is combinational from state (state != IDLE).
// STRUCTURE
//  - Package uart_pkg: typedef enum logic [1:0] {IDLE,START,DATA,STOP} uart_state_t;
//    localparam DATA_BITS=8; shared default clock_freq/baud_rate constants.
//  - Sub-module uart_baud_tick #(clock_freq,baud_rate,OVERSAMPLE) (clk,rst,tick): tick generator,
//    reusable by transmit side. Sync, FSM, shift register stay in uart_rx.
//  - Target size: ~150-250 lines RTL total.
// TESTING (defaults: TICK_DIV=65, bit period = 16*65 = 1040 clk)
//  1. Drive 0xA5 as 8N1, 1040 clk/bit -> rx_data=8'hA5, one rx_done pulse, rx_err never high.
//  2. Low glitch of 3 ticks (195 clk) on idle line -> rx_busy pulses, no rx_done/rx_err, rx_data holds.
//  3. Frame 0x3C with stop bit 0 -> one rx_err pulse, no rx_done, rx_data keeps previous 8'hA5.
//  4. Back-to-back 0x00 then 0xFF, no idle gap -> two rx_done pulses, data 8'h00 then 8'hFF.
//  5. rst=0 for 2 clk at mid data bit 4 -> all outputs reset values; following 0x5A received ok.
//  6. Baud skew ±2% (1019 / 1061 clk/bit) on 0x96 -> received correctly, no rx_err.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive and transmit sides.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned CLOCK_FREQ_DEF = 10_000_000;
  localparam int unsigned BAUD_RATE_DEF  = 9600;
  localparam int unsigned OVERSAMPLE_DEF = 16;

  // Clocks per oversample tick, truncated; never below 1 so the divider stays legal.
  function automatic int unsigned tick_div(input int unsigned freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned div;
    div = freq / (baud * os);
    return (div < 1) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running divider producing a one-clock oversample tick enable.
module uart_baud_tick import uart_pkg::*; #(
  parameter int unsigned clock_freq = CLOCK_FREQ_DEF,
  parameter int unsigned baud_rate  = BAUD_RATE_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned TICK_DIV = tick_div(clock_freq, baud_rate, OVERSAMPLE);
  localparam int unsigned CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input sync, 16x oversampled FSM, byte strobe and framing-error strobe.
module uart_rx import uart_pkg::*; #(
  parameter int unsigned clock_freq = CLOCK_FREQ_DEF,
  parameter int unsigned baud_rate  = BAUD_RATE_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_err,
  output logic                 rx_busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  logic tick;

  uart_baud_tick #(
    .clock_freq (clock_freq),
    .baud_rate  (baud_rate),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic                 rx_meta_q, rx_s_q;
  uart_state_t          state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bidx_q, bidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // START waits half a bit so every later sample lands mid-bit; STOP exits mid-stop-bit.
  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d = START;
            scnt_d  = '0;
          end
        end
        START: begin
          if (scnt_q == HALF_LAST) begin
            scnt_d = '0;
            if (!rx_s_q) begin
              state_d = DATA;
              bidx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        DATA: begin
          if (scnt_q == BIT_LAST) begin
            scnt_d  = '0;
            shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
            if (bidx_q == IDX_LAST) state_d = STOP;
            else                    bidx_d  = bidx_q + BW'(1);
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        STOP: begin
          if (scnt_q == BIT_LAST) begin
            scnt_d  = '0;
            state_d = IDLE;
            if (rx_s_q) begin
              data_d = shreg_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_data = data_q;
  assign rx_done = done_q;
  assign rx_err  = err_q;
  assign rx_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level expectation queue plus per-cycle output checks.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 10_000;
  localparam int unsigned OS     = 16;
  localparam int T      = CLK_HZ / (BAUD * OS);   // 10 clk per tick
  localparam int BP     = OS * T;                 // 160 clk per bit
  localparam int LAT_LO = (9 * OS + OS / 2) * T;  // 9.5 bit times from start edge
  localparam int LAT_HI = LAT_LO + T + 4;         // plus sync delay and tick phase

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, rx_err, rx_busy;

  uart_rx #(
    .clock_freq (CLK_HZ),
    .baud_rate  (BAUD),
    .OVERSAMPLE (OS)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx      (rx),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .rx_err  (rx_err),
    .rx_busy (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    longint     edge_c;
  } exp_t;

  exp_t       expq[$];
  int         checks = 0;
  int         errors = 0;
  longint     cyc = 0;
  bit         rst_at_edge = 1'b0;
  logic [7:0] model_data = 8'h00;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         busy_cnt = 0;
  bit         prev_done = 1'b0;
  bit         prev_err = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_at_edge) begin
      model_data = 8'h00;
      check(!rx_done && !rx_err && !rx_busy, "reset_outputs", {rx_done, rx_err, rx_busy}, 0);
    end else begin
      check(!(rx_done && rx_err), "done_err_exclusive", {rx_done, rx_err}, 0);
      check(!(rx_done && prev_done) && !(rx_err && prev_err), "strobe_width",
            {prev_done, rx_done, prev_err, rx_err}, 0);
      if (rx_done) done_cnt++;
      if (rx_err)  err_cnt++;
      if (rx_busy) busy_cnt++;
      if (rx_done || rx_err) begin
        if (expq.size() == 0) begin
          check(1'b0, "unexpected_strobe", {rx_done, rx_err}, 0);
        end else begin
          e = expq.pop_front();
          check(rx_err == e.err, "strobe_kind", rx_err, e.err);
          check(cyc >= e.edge_c + LAT_LO && cyc <= e.edge_c + LAT_HI, "strobe_latency",
                cyc - e.edge_c, LAT_LO);
          if (!e.err) model_data = e.data;
        end
      end
      if (expq.size() > 0 && cyc > expq[0].edge_c + LAT_HI) begin
        check(1'b0, "strobe_timeout", cyc - expq[0].edge_c, LAT_HI);
        void'(expq.pop_front());
      end
    end
    check(rx_data == model_data, "rx_data", rx_data, model_data);
    prev_done = rx_done;
    prev_err  = rx_err;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit stop, input int bp, input bit expect_it);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    if (expect_it) expq.push_back('{err: !stop, data: d, edge_c: cyc});
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      idle(bp);
    end
  endtask

  initial begin
    int d0, e0, b0;
    idle(3);
    check(rx_data == 8'h00 && !rx_done && !rx_err && !rx_busy, "reset_state",
          {rx_data, rx_done, rx_err, rx_busy}, 0);
    rst = 1'b1;
    idle(4 * BP);

    // single good frame
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5, 1'b1, BP, 1'b1);
    idle(3 * BP);
    check(rx_data == 8'hA5, "t1_data", rx_data, 8'hA5);
    check(done_cnt - d0 == 1, "t1_done_count", done_cnt - d0, 1);
    check(err_cnt == e0, "t1_no_err", err_cnt - e0, 0);

    // 3-tick low glitch on an idle line
    d0 = done_cnt; e0 = err_cnt; b0 = busy_cnt;
    rx = 1'b0;
    idle(3 * T);
    rx = 1'b1;
    idle(4 * BP);
    check(busy_cnt > b0, "t2_busy_pulsed", busy_cnt - b0, 1);
    check(!rx_busy, "t2_busy_idle", rx_busy, 0);
    check(done_cnt == d0 && err_cnt == e0, "t2_no_strobe", (done_cnt - d0) + (err_cnt - e0), 0);
    check(rx_data == 8'hA5, "t2_data_hold", rx_data, 8'hA5);

    // framing error
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 1'b0, BP, 1'b1);
    rx = 1'b1;
    idle(3 * BP);
    check(err_cnt - e0 == 1, "t3_err_count", err_cnt - e0, 1);
    check(done_cnt == d0, "t3_no_done", done_cnt - d0, 0);
    check(rx_data == 8'hA5, "t3_data_kept", rx_data, 8'hA5);

    // back-to-back frames
    d0 = done_cnt;
    send(8'h00, 1'b1, BP, 1'b1);
    check(rx_data == 8'h00, "t4_first_data", rx_data, 8'h00);
    send(8'hFF, 1'b1, BP, 1'b1);
    idle(3 * BP);
    check(done_cnt - d0 == 2, "t4_done_count", done_cnt - d0, 2);
    check(rx_data == 8'hFF, "t4_second_data", rx_data, 8'hFF);

    // reset in the middle of data bit 4; remaining bits of 0xF3 are all high
    fork
      send(8'hF3, 1'b1, BP, 1'b0);
      begin
        idle(5 * BP + BP / 2);
        rst = 1'b0;
        idle(2);
        check(rx_data == 8'h00 && !rx_busy && !rx_done && !rx_err, "t5_reset_outputs",
              {rx_data, rx_busy, rx_done, rx_err}, 0);
        rst = 1'b1;
      end
    join
    idle(2 * BP);
    d0 = done_cnt; e0 = err_cnt;
    send(8'h5A, 1'b1, BP, 1'b1);
    idle(3 * BP);
    check(rx_data == 8'h5A, "t5_data", rx_data, 8'h5A);
    check(done_cnt - d0 == 1 && err_cnt == e0, "t5_strobes", done_cnt - d0, 1);

    // +-2% baud skew
    d0 = done_cnt; e0 = err_cnt;
    send(8'h96, 1'b1, BP - BP / 50, 1'b1);
    idle(3 * BP);
    send(8'h96, 1'b1, BP + BP / 50, 1'b1);
    idle(3 * BP);
    check(rx_data == 8'h96, "t6_data", rx_data, 8'h96);
    check(done_cnt - d0 == 2, "t6_done_count", done_cnt - d0, 2);
    check(err_cnt == e0, "t6_no_err", err_cnt - e0, 0);

    idle(BP);
    check(expq.size() == 0, "queue_drained", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
